// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO phase generator.
//   quadrant_t : 2-bit phase quadrant, Q0 = [0,90) ... Q3 = [270,360)
//   LFSR_SEED  : dither LFSR seed; also used when sync_i restarts the phase
//   LFSR_TAPS  : Fibonacci feedback mask for taps 16,14,13,11
package nco_pkg;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/nco_phase_gen_if.sv
// Control and sample bus of the NCO phase generator.
//   master : drives enable, config, sync and ready; receives the sample
//   slave  : the generator side
// Signals:
//   en_i, cfg_load_i, ftw_i, offset_i, sync_i, ready_i  (master -> slave)
//   valid_o, quadrant_o, angle_o, wrap_o                (slave -> master)
interface nco_phase_gen_if #(
   parameter int FW = 32,
   parameter int AW = 16
) ();
   logic          en_i;
   logic          cfg_load_i;
   logic [FW-1:0] ftw_i;
   logic [FW-1:0] offset_i;
   logic          sync_i;
   logic          ready_i;
   logic          valid_o;
   logic [1:0]    quadrant_o;
   logic [AW-1:0] angle_o;
   logic          wrap_o;

   modport master (
      output en_i, cfg_load_i, ftw_i, offset_i, sync_i, ready_i,
      input  valid_o, quadrant_o, angle_o, wrap_o
   );

   modport slave (
      input  en_i, cfg_load_i, ftw_i, offset_i, sync_i, ready_i,
      output valid_o, quadrant_o, angle_o, wrap_o
   );
endinterface

// File: rtl/nco_phase_round.sv
// Combinational phase offset add and round to quadrant + angle.
// Ports:
//   acc_i      : accumulator phase (PW bits, already forced to 0 on sync)
//   offset_i   : phase offset (PW bits)
//   dith_i     : LFSR state, only present with NCO_PHASE_DITHER_EN
//   quadrant_o : top 2 bits of the rounded phase
//   angle_o    : next AW bits of the rounded phase
// Macro NCO_PHASE_DITHER_EN: the rounding constant becomes the low LFSR
// bits left-aligned in the discarded field instead of a fixed half LSB.
module nco_phase_round
   import nco_pkg::*;
#(
   parameter int PW = 32,
   parameter int AW = 16
) (
   input  logic [PW-1:0] acc_i,
   input  logic [PW-1:0] offset_i,
`ifdef NCO_PHASE_DITHER_EN
   input  logic [15:0]   dith_i,
`endif
   output quadrant_t     quadrant_o,
   output logic [AW-1:0] angle_o
);
   // Bits below the output field that are dropped by rounding.
   localparam int DROP = PW - AW - 2;
`ifdef NCO_PHASE_DITHER_EN
   localparam int DTW = (DROP < 16) ? DROP : 16;
`endif

   logic [PW-1:0] p;
   logic [PW-1:0] rnd;
   logic [PW-1:0] s;
   logic [AW+1:0] top;

   always_comb begin
      p   = acc_i + offset_i;
`ifdef NCO_PHASE_DITHER_EN
      rnd = PW'(dith_i[DTW-1:0]) << (DROP - DTW);
`else
      rnd = PW'(1) << (DROP - 1);
`endif
      // Carry out of bit PW-1 is dropped, so rounding past 360 deg wraps to 0.
      s          = p + rnd;
      top        = (AW+2)'(s >> DROP);
      quadrant_o = quadrant_t'(top[AW+1:AW]);
      angle_o    = top[AW-1:0];
   end
endmodule

// File: rtl/nco_phase_gen.sv
// Numerically controlled phase generator feeding a CORDIC sin/cos stage.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus (slave)    : en/cfg_load/ftw/offset/sync/ready in,
//                    valid/quadrant/angle/wrap out
// A sample is produced on every advance (en_i while the output slot is
// free); the output holds while valid_o is set and ready_i is low.
// Macro NCO_PHASE_DITHER_EN enables a 16-bit LFSR rounding dither.
module nco_phase_gen
   import nco_pkg::*;
#(
   parameter int PW = 32,
   parameter int AW = 16,
   parameter int FW = PW
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   nco_phase_gen_if.slave bus
);
   logic [PW-1:0] acc_q, acc_d;
   logic          carry_q, carry_d;
   logic [PW-1:0] ftw_q, ftw_d;
   logic [PW-1:0] off_q, off_d;
   logic          valid_q, valid_d;
   quadrant_t     quad_q, quad_d;
   logic [AW-1:0] angle_q, angle_d;
   logic          wrap_q, wrap_d;

   logic          adv;
   logic [PW-1:0] rnd_acc;
   quadrant_t     rnd_quad;
   logic [AW-1:0] rnd_angle;

`ifdef NCO_PHASE_DITHER_EN
   logic [15:0]   lfsr_q, lfsr_d;
`endif

   // sync_i restarts phase: the sample sees an accumulator of 0.
   assign rnd_acc = bus.sync_i ? '0 : acc_q;

   nco_phase_round #(.PW(PW), .AW(AW)) u_round (
      .acc_i      (rnd_acc),
      .offset_i   (off_q),
`ifdef NCO_PHASE_DITHER_EN
      .dith_i     (lfsr_q),
`endif
      .quadrant_o (rnd_quad),
      .angle_o    (rnd_angle)
   );

   always_comb begin
      adv     = bus.en_i && (!valid_q || bus.ready_i);
      acc_d   = acc_q;
      carry_d = carry_q;
      ftw_d   = ftw_q;
      off_d   = off_q;
      valid_d = valid_q;
      quad_d  = quad_q;
      angle_d = angle_q;
      wrap_d  = wrap_q;

      // Config registers load now but are only seen from the next advance.
      if (bus.cfg_load_i) begin
         ftw_d = PW'(bus.ftw_i);
         off_d = PW'(bus.offset_i);
      end

      if (adv) begin
         quad_d  = rnd_quad;
         angle_d = rnd_angle;
         valid_d = 1'b1;
         if (bus.sync_i) begin
            acc_d   = ftw_q;
            carry_d = 1'b0;
            wrap_d  = 1'b0;
         end else begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, ftw_q};
            // wrap marks the first sample after the carry-out.
            wrap_d = carry_q;
         end
      end else begin
         if (bus.ready_i) valid_d = 1'b0;
         if (bus.sync_i) begin
            acc_d   = '0;
            carry_d = 1'b0;
         end
      end
   end

`ifdef NCO_PHASE_DITHER_EN
   always_comb begin
      lfsr_d = lfsr_q;
      if (bus.sync_i)
         lfsr_d = LFSR_SEED;
      else if (adv)
         lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) lfsr_q <= LFSR_SEED;
      else          lfsr_q <= lfsr_d;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         ftw_q   <= '0;
         off_q   <= '0;
         valid_q <= 1'b0;
         quad_q  <= Q0;
         angle_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
         ftw_q   <= ftw_d;
         off_q   <= off_d;
         valid_q <= valid_d;
         quad_q  <= quad_d;
         angle_q <= angle_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.valid_o    = valid_q;
   assign bus.quadrant_o = quad_q;
   assign bus.angle_o    = angle_q;
   assign bus.wrap_o     = wrap_q;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen (default build, PW=32, AW=16).
// A phase-arithmetic reference model is stepped one clock behind the
// stimulus and compared against the DUT on every falling edge; directed
// sections pin the model with hand-computed literals.
module tb_nco_phase_gen;
   localparam longint unsigned TWO32 = 64'h1_0000_0000;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   nco_phase_gen_if #(.FW(32), .AW(16)) bus ();

   nco_phase_gen #(.PW(32), .AW(16), .FW(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: the value every DUT register must hold
   longint unsigned m_acc, m_ftw, m_off;
   bit              m_carry, m_valid, m_wrap;
   int unsigned     m_quad, m_angle;

   task automatic model_reset();
      m_acc = 0; m_ftw = 0; m_off = 0; m_carry = 0;
      m_valid = 0; m_wrap = 0; m_quad = 0; m_angle = 0;
   endtask

   // Phase -> quadrant/angle: round to 18 bits (half LSB = 2^13), mod 2^18.
   task automatic model_step();
      longint unsigned p, r, s;
      bit adv;
      if (!rst_n) begin
         model_reset();
         return;
      end
      adv = bus.en_i && (!m_valid || bus.ready_i);
      if (adv) begin
         p       = bus.sync_i ? m_off : (m_acc + m_off) % TWO32;
         r       = ((p + 64'd8192) / 64'd16384) % 64'd262144;
         m_quad  = int'(r / 65536);
         m_angle = int'(r % 65536);
         m_valid = 1;
         if (bus.sync_i) begin
            m_wrap = 0; m_acc = m_ftw; m_carry = 0;
         end else begin
            m_wrap  = m_carry;
            s       = m_acc + m_ftw;
            m_carry = (s >= TWO32);
            m_acc   = s % TWO32;
         end
      end else begin
         if (bus.ready_i) m_valid = 0;
         if (bus.sync_i) begin
            m_acc = 0; m_carry = 0;
         end
      end
      if (bus.cfg_load_i) begin
         m_ftw = longint'(bus.ftw_i);
         m_off = longint'(bus.offset_i);
      end
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit en, input bit cfg, input logic [31:0] ftw,
                        input logic [31:0] off, input bit sync, input bit rdy);
      bus.en_i = en; bus.cfg_load_i = cfg; bus.ftw_i = ftw;
      bus.offset_i = off; bus.sync_i = sync; bus.ready_i = rdy;
   endtask

   // Advance one edge; afterwards the model matches the DUT's new state.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   // Compare process: every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         n_chk++;
         if (bus.valid_o !== m_valid || bus.quadrant_o !== m_quad[1:0] ||
             bus.angle_o !== m_angle[15:0] || bus.wrap_o !== m_wrap) begin
            n_fail++;
            $display("FAIL model t=%0t: got v=%0b q=%0d a=%h w=%0b expected v=%0b q=%0d a=%h w=%0b",
                     $time, bus.valid_o, bus.quadrant_o, bus.angle_o, bus.wrap_o,
                     m_valid, m_quad[1:0], m_angle[15:0], m_wrap);
         end
      end
   end

   logic [15:0] hold_a;
   logic [1:0]  hold_q;

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk("reset_valid", bus.valid_o, 0);
      chk("reset_quad",  bus.quadrant_o, 0);
      chk("reset_angle", bus.angle_o, 0);
      chk("reset_wrap",  bus.wrap_o, 0);
      rst_n = 1'b1;

      // Quarter-turn stepping
      drive(0, 1, 32'h4000_0000, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 1, 1); tick();
      chk("qt_s1_quad", bus.quadrant_o, 0);
      chk("qt_s1_angle", bus.angle_o, 0);
      chk("qt_s1_wrap", bus.wrap_o, 0);
      drive(1, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("qt_quad", bus.quadrant_o, i % 4);
         chk("qt_angle", bus.angle_o, 0);
         chk("qt_wrap", bus.wrap_o, (i == 4) ? 1 : 0);
         chk("qt_valid", bus.valid_o, 1);
      end

      // Round wrap at the top of the circle
      drive(0, 1, 0, 32'hFFFF_E000, 0, 1); tick();
      drive(1, 0, 0, 0, 1, 1); tick();
      chk("rw_half_quad", bus.quadrant_o, 0);
      chk("rw_half_angle", bus.angle_o, 0);
      drive(0, 1, 0, 32'hFFFF_DFFF, 0, 1); tick();
      drive(1, 0, 0, 0, 1, 1); tick();
      chk("rw_below_quad", bus.quadrant_o, 3);
      chk("rw_below_angle", bus.angle_o, 16'hFFFF);

      // Backpressure
      drive(0, 1, 32'h0100_0000, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 1, 1); tick();
      drive(1, 0, 0, 0, 0, 1); tick(); tick();
      chk("bp_pre_angle", bus.angle_o, 16'h0800);
      hold_a = bus.angle_o; hold_q = bus.quadrant_o;
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid", bus.valid_o, 1);
         chk("bp_hold_angle", bus.angle_o, hold_a);
         chk("bp_hold_quad", bus.quadrant_o, hold_q);
      end
      drive(1, 0, 0, 0, 0, 1); tick();
      chk("bp_rel_angle", bus.angle_o, 16'h0C00);
      tick();
      chk("bp_next_angle", bus.angle_o, 16'h1000);

      // Sync mid-stream with a quarter-turn offset
      drive(0, 1, 32'h0100_0000, 32'h4000_0000, 0, 1); tick();
      drive(1, 0, 0, 0, 1, 1); tick();
      chk("sync_quad", bus.quadrant_o, 1);
      chk("sync_angle", bus.angle_o, 0);
      drive(1, 0, 0, 0, 0, 1); tick();
      chk("sync_next_quad", bus.quadrant_o, 1);
      chk("sync_next_angle", bus.angle_o, 16'h0400);

      // Asynchronous reset between edges
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.valid_o, 0);
      chk("arst_quad", bus.quadrant_o, 0);
      chk("arst_angle", bus.angle_o, 0);
      model_reset();
      #4;
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_valid", bus.valid_o, 1);
         chk("post_rst_quad", bus.quadrant_o, 0);
         chk("post_rst_angle", bus.angle_o, 0);
         chk("post_rst_wrap", bus.wrap_o, 0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] f, o;
         case ($urandom_range(0, 3))
            0: f = $urandom;
            1: f = $urandom_range(0, 8192);
            2: f = 32'h0;
            default: f = 32'h4000_0000 - $urandom_range(0, 3);
         endcase
         o = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_E000 + $urandom_range(0, 3) - 2);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, f, o,
               $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
         tick();
      end

      drive(0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
